// File: rtl/controller_part4_if.sv
// controller_part4_if: load/result handshake and datapath control bundle
interface controller_part4_if #(
  parameter int N = 8,
  parameter int LOG2N = $clog2(N)
);
  logic in_valid;
  logic in_ready;
  logic [LOG2N-1:0] addr_x;
  logic wr_en_x;
  logic [2*LOG2N-1:0] addr_w;
  logic wr_en_w;
  logic clear_acc;
  logic en_acc;
  logic out_valid;
  logic out_ready;
  logic [LOG2N-1:0] out_row;
  logic done;
  modport master (
    input in_valid, out_ready,
    output in_ready, addr_x, wr_en_x, addr_w, wr_en_w, clear_acc, en_acc, out_valid, out_row, done
  );
  modport slave (
    output in_valid, out_ready,
    input in_ready, addr_x, wr_en_x, addr_w, wr_en_w, clear_acc, en_acc, out_valid, out_row, done
  );
endinterface

// File: rtl/controller_part4.sv
// controller_part4: load/clear/MAC/output sequencer for the N-element matrix-vector datapath
module controller_part4 #(
  parameter int N = 8,
  parameter int LOG2N = $clog2(N)
) (
  input logic clk,
  input logic rst,
  controller_part4_if.master b
);
  typedef enum logic [2:0] {LOAD_X, LOAD_W, CLEAR, MAC, OUT} state_t;
  localparam int LW = 2 * LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LW-1:0] X_LAST = LW'(N - 1);
  localparam logic [LW-1:0] W_LAST = LW'(N * N - 1);
  state_t state, state_n;
  logic [LW-1:0] ld_cnt;
  logic [LOG2N-1:0] k, row;
  logic acc_in, acc_out, x_end, w_end;
  assign acc_in = b.in_valid && (state == LOAD_X || state == LOAD_W);
  assign acc_out = b.out_ready && state == OUT;
  assign x_end = acc_in && state == LOAD_X && ld_cnt == X_LAST;
  assign w_end = acc_in && state == LOAD_W && ld_cnt == W_LAST;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD_X;
      ld_cnt <= '0;
      k <= '0;
      row <= '0;
    end else begin
      state <= state_n;
      ld_cnt <= (acc_out || x_end) ? '0 : ld_cnt + LW'(acc_in);
      k <= state == MAC ? k + 1'b1 : '0;
      row <= state == LOAD_W ? '0 : row + LOG2N'(acc_out);
    end
  end
  always_comb begin
    state_n = state;
    b.in_ready = 1'b0;
    b.addr_x = '0;
    b.wr_en_x = 1'b0;
    b.addr_w = '0;
    b.wr_en_w = 1'b0;
    b.clear_acc = 1'b0;
    b.en_acc = 1'b0;
    b.out_valid = 1'b0;
    b.out_row = '0;
    b.done = 1'b0;
    if (rst) begin
      case (state)
        LOAD_X: begin
          b.in_ready = 1'b1;
          b.wr_en_x = b.in_valid;
          b.addr_x = ld_cnt[LOG2N-1:0];
          state_n = x_end ? LOAD_W : LOAD_X;
        end
        LOAD_W: begin
          b.in_ready = 1'b1;
          b.wr_en_w = b.in_valid;
          b.addr_w = ld_cnt;
          state_n = w_end ? CLEAR : LOAD_W;
        end
        CLEAR: begin
          b.clear_acc = 1'b1;
          state_n = MAC;
        end
        MAC: begin
          b.en_acc = 1'b1;
          b.addr_x = k;
          b.addr_w = {row, k};
          state_n = k == LAST ? OUT : MAC;
        end
        OUT: begin
          b.out_valid = 1'b1;
          b.out_row = row;
          b.done = b.out_ready && row == LAST;
          state_n = b.out_ready ? (row == LAST ? LOAD_X : CLEAR) : OUT;
        end
        default: state_n = LOAD_X;
      endcase
    end
  end
endmodule

// File: tb/tb_controller_part4.sv
// tb_controller_part4: directed checks of controller_part4 driving a behavioural datapath
module tb_controller_part4;
  localparam int N = 8;
  localparam int LOG2N = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [13:0] input_data = '0;
  logic signed [13:0] xm [N];
  logic signed [13:0] wm [N*N];
  logic signed [27:0] acc = '0;
  logic signed [27:0] prod;
  logic signed [28:0] sum;
  logic signed [13:0] xv [N];
  logic signed [13:0] wv [N*N];
  longint ev [N];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int viol = 0;
  int tf, td;
  controller_part4_if #(.N(N)) b ();
  controller_part4 #(.N(N)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  always @(negedge clk) cyc++;
  assign prod = xm[b.addr_x] * wm[b.addr_w];
  assign sum = acc + prod;
  always @(posedge clk) begin
    if (b.wr_en_x) xm[b.addr_x] <= input_data;
    if (b.wr_en_w) wm[b.addr_w] <= input_data;
    if (b.clear_acc) acc <= '0;
    else if (b.en_acc) acc <= sum > 29'sd134217727 ? 28'sh7FFFFFF : sum < -29'sd134217728 ? 28'sh8000000 : sum[27:0];
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic logic [18:0] outs();
    return {b.in_ready, b.addr_x, b.wr_en_x, b.addr_w, b.wr_en_w, b.clear_acc, b.en_acc, b.out_valid, b.out_row, b.done};
  endfunction
  task automatic send(input logic signed [13:0] w, input bit gap, input int idx, input bit is_w);
    int n = 0;
    if (gap) begin
      @(negedge clk);
      b.in_valid = 1'b0;
    end
    @(negedge clk);
    b.in_valid = 1'b1;
    input_data = w;
    #1;
    while (!b.in_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 10) chk("ld_timeout", 1, 0);
    if (is_w ? (b.addr_w != 6'(idx) || !b.wr_en_w) : (b.addr_x != 3'(idx) || !b.wr_en_x)) viol++;
  endtask
  task automatic load(input bit gap);
    int c0 = cyc;
    viol = 0;
    for (int i = 0; i < N; i++) send(xv[i], gap, i, 1'b0);
    for (int i = 0; i < N * N; i++) send(wv[i], gap, i, 1'b1);
    chk("ld_addr", viol, 0);
    chk("ld_cycles", cyc - c0, gap ? 2 * N * (N + 1) : N * (N + 1));
  endtask
  task automatic collect(input int stall_row, output int t_first, output int t_done);
    int r = 0;
    int t = 0;
    int stalls = 0;
    longint held = 0;
    viol = 0;
    t_first = -1;
    t_done = -1;
    while (r < N && t < 400) begin
      @(negedge clk);
      t++;
      b.in_valid = 1'b1;
      input_data = 14'h1555;
      b.out_ready = !(b.out_valid && int'(b.out_row) == stall_row && stalls < 5);
      #1;
      if (b.in_ready || b.wr_en_x || b.wr_en_w) viol++;
      if (b.out_valid && (b.en_acc || b.clear_acc)) viol++;
      if (b.out_valid && t_first < 0) t_first = t;
      if (!b.out_ready) begin
        if (stalls == 0) held = acc;
        else if (!b.out_valid || int'(b.out_row) != stall_row || acc != held || b.done) viol++;
        stalls++;
      end else if (b.out_valid) begin
        chk("row", b.out_row, r);
        chk("data", acc, ev[r]);
        chk("done", b.done, r == N - 1);
        if (b.done) t_done = t;
        r++;
      end else if (b.done) viol++;
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    if (r < N) chk("out_timeout", r, N);
    chk("quiet", viol, 0);
    chk("stalls", stalls, stall_row < 0 ? 0 : 5);
  endtask
  task automatic set_ident();
    for (int i = 0; i < N; i++) begin
      xv[i] = 14'(i + 1);
      ev[i] = i + 1;
    end
    for (int i = 0; i < N * N; i++) wv[i] = (i / N == i % N) ? 14'sd1 : 14'sd0;
  endtask
  task automatic set_sum();
    for (int i = 0; i < N; i++) begin
      xv[i] = 14'(i + 1);
      ev[i] = 36 * (i + 1);
    end
    for (int i = 0; i < N * N; i++) wv[i] = 14'(i / N + 1);
  endtask
  task automatic set_sat(input logic signed [13:0] xval, input longint e);
    for (int i = 0; i < N; i++) begin
      xv[i] = xval;
      ev[i] = e;
    end
    for (int i = 0; i < N * N; i++) wv[i] = 14'sd8191;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", outs(), 0);
    b.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", b.in_ready, 1);
    chk("rel_addr_x", b.addr_x, 0);
    set_ident();
    load(1'b0);
    collect(-1, tf, td);
    chk("row_latency", tf, N + 2);
    chk("done_cycles", td, N * (N + 2));
    set_sum();
    load(1'b0);
    collect(-1, tf, td);
    chk("done_cycles_b2b", td, N * (N + 2));
    set_ident();
    load(1'b1);
    collect(3, tf, td);
    set_sat(14'sd8191, 134217727);
    load(1'b0);
    collect(-1, tf, td);
    set_sat(-14'sd8192, -134217728);
    load(1'b0);
    collect(-1, tf, td);
    set_sum();
    load(1'b0);
    for (int t = 1; t <= 26; t++) begin
      @(negedge clk);
      b.in_valid = 1'b0;
    end
    #1;
    chk("mac_en", b.en_acc, 1);
    chk("mac_addr_w", b.addr_w, 2 * N + 4);
    chk("mac_addr_x", b.addr_x, 4);
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 0);
    @(negedge clk);
    #1;
    chk("rst_hold_outs", outs(), 0);
    rst = 1'b1;
    #1;
    chk("rel2_ready", b.in_ready, 1);
    chk("rel2_addr_x", b.addr_x, 0);
    set_ident();
    load(1'b0);
    collect(-1, tf, td);
    chk("done_cycles_post_rst", td, N * (N + 2));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
